// File: rtl/hazard_scoreboard.sv
// D-stage stall unit: per-register Tnew countdown scoreboard plus MD-unit busy counter.
// Stall terms are combinational on D inputs; scoreboard updates appear one cycle after issue.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_wa,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_start,
  input  logic          d_md_div,
  input  logic          d_md_use,
  input  logic          kill,
  output logic          stall,
  output logic          stall_rs,
  output logic          stall_rt,
  output logic          stall_md,
  output logic          md_busy,
  output logic          md_go
);

  localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int MW     = $clog2(MD_MAX + 1);
  localparam logic [TW-1:0] TUSE_NONE = '1;

  logic [TW-1:0] cnt_q [1:NREG-1];
  logic [TW-1:0] cnt_d [1:NREG-1];
  logic [MW-1:0] md_cnt_q;
  logic [MW-1:0] md_cnt_d;
  logic [TW-1:0] cnt_rs;
  logic [TW-1:0] cnt_rt;
  logic          issue;

  // Register 0 has no entry, so any address outside 1..NREG-1 reads as zero.
  always_comb begin
    cnt_rs = '0;
    cnt_rt = '0;
    for (int r = 1; r < NREG; r++) begin
      if (d_rs == AW'(r)) cnt_rs = cnt_q[r];
      if (d_rt == AW'(r)) cnt_rt = cnt_q[r];
    end
  end

  always_comb begin
    stall_rs = d_valid && (d_tuse_rs != TUSE_NONE) && (d_rs != '0) && (cnt_rs > d_tuse_rs);
    stall_rt = d_valid && (d_tuse_rt != TUSE_NONE) && (d_rt != '0) && (cnt_rt > d_tuse_rt);
    stall_md = d_valid && d_md_use && (md_cnt_q != '0);
    stall    = stall_rs || stall_rt || stall_md;
    md_busy  = (md_cnt_q != '0);
    issue    = d_valid && !stall && !kill && !reset;
    md_go    = issue && d_md_start;
  end

  // A new writer overrides the decrement; kill wipes the table but not the MD counter.
  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - TW'(1) : '0;
      if (issue && (d_wa == AW'(r))) cnt_d[r] = d_tnew;
      if (kill) cnt_d[r] = '0;
    end
    md_cnt_d = (md_cnt_q != '0) ? md_cnt_q - MW'(1) : '0;
    if (md_go) md_cnt_d = d_md_div ? MW'(DIV_LAT) : MW'(MULT_LAT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 1; r < NREG; r++) cnt_q[r] <= '0;
      md_cnt_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus random traffic against a
// ready-time reference model; predictions are queued at drive time and checked at negedge.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use, kill;
  logic       stall, stall_rs, stall_rt, stall_md, md_busy, md_go;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .d_md_use(d_md_use), .kill(kill),
    .stall(stall), .stall_rs(stall_rs), .stall_rt(stall_rt), .stall_md(stall_md),
    .md_busy(md_busy), .md_go(md_go)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs, rt, wa;
    logic [1:0] tuse_rs, tuse_rt, tnew;
    logic       md_start, md_div, md_use, kill, rst;
  } stim_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [5:0] exp_q[$];
  logic [5:0] obs;          // {stall, stall_rs, stall_rt, stall_md, md_busy, md_go}

  // Reference model: absolute cycle at which each register / the MD unit is free.
  int cyc;
  int ready_at[32];
  int md_free_at;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int left(input logic [4:0] r);
    if (r == 0 || ready_at[r] <= cyc) return 0;
    return ready_at[r] - cyc;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s.valid = 0; s.rs = 0; s.rt = 0; s.wa = 0;
    s.tuse_rs = 2'b11; s.tuse_rt = 2'b11; s.tnew = 0;
    s.md_start = 0; s.md_div = 0; s.md_use = 0; s.kill = 0; s.rst = 0;
    return s;
  endfunction

  function automatic stim_t wr(input logic [4:0] wa, input logic [1:0] tnew);
    stim_t s = nop();
    s.valid = 1; s.wa = wa; s.tnew = tnew;
    return s;
  endfunction

  function automatic stim_t rd_rs(input logic [4:0] rs, input logic [1:0] tuse);
    stim_t s = nop();
    s.valid = 1; s.rs = rs; s.tuse_rs = tuse;
    return s;
  endfunction

  function automatic stim_t rd_rt(input logic [4:0] rt, input logic [1:0] tuse);
    stim_t s = nop();
    s.valid = 1; s.rt = rt; s.tuse_rt = tuse;
    return s;
  endfunction

  function automatic stim_t md_op(input logic is_div);
    stim_t s = nop();
    s.valid = 1; s.md_start = 1; s.md_div = is_div; s.md_use = 1;
    return s;
  endfunction

  // Called at posedge+1; drives one D-stage cycle, checks at negedge, advances the model.
  task automatic drive(input stim_t s);
    logic srs, srt, smd, st, iss, go, busy;
    int   md_left;
    d_valid = s.valid; d_rs = s.rs; d_rt = s.rt; d_wa = s.wa;
    d_tuse_rs = s.tuse_rs; d_tuse_rt = s.tuse_rt; d_tnew = s.tnew;
    d_md_start = s.md_start; d_md_div = s.md_div; d_md_use = s.md_use;
    kill = s.kill; reset = s.rst;
    md_left = (md_free_at > cyc) ? md_free_at - cyc : 0;
    busy = (md_left > 0);
    srs  = s.valid && (s.tuse_rs != 2'b11) && (s.rs != 0) && (left(s.rs) > int'(s.tuse_rs));
    srt  = s.valid && (s.tuse_rt != 2'b11) && (s.rt != 0) && (left(s.rt) > int'(s.tuse_rt));
    smd  = s.valid && s.md_use && busy;
    st   = srs || srt || smd;
    iss  = s.valid && !st && !s.kill && !s.rst;
    go   = iss && s.md_start;
    exp_q.push_back({st, srs, srt, smd, busy, go});
    @(negedge clk);
    obs = {stall, stall_rs, stall_rt, stall_md, md_busy, md_go};
    chk("outs", {26'd0, obs}, {26'd0, exp_q.pop_front()});
    @(posedge clk);
    #1;
    if (s.rst) begin
      foreach (ready_at[i]) ready_at[i] = 0;
      md_free_at = 0;
    end else begin
      if (s.kill) foreach (ready_at[i]) ready_at[i] = 0;
      else if (iss && s.wa != 0) ready_at[s.wa] = cyc + 1 + int'(s.tnew);
      if (go) md_free_at = cyc + 1 + (s.md_div ? 10 : 5);
    end
    cyc++;
  endtask

  // Re-present one instruction until it issues; n = stall cycles seen (bounded).
  task automatic hold(input stim_t s, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(s);
      if (obs[5]) n++;
      else break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int    n;
    s = nop();
    d_valid = 0; d_rs = 0; d_rt = 0; d_wa = 0; d_tuse_rs = 2'b11; d_tuse_rt = 2'b11;
    d_tnew = 0; d_md_start = 0; d_md_div = 0; d_md_use = 0; kill = 0; reset = 1;
    cyc = 0; md_free_at = 0;
    foreach (ready_at[i]) ready_at[i] = 0;
    @(posedge clk);
    #1;

    // Reset with busy-looking inputs: everything reads zero
    s = rd_rs(1, 0); s.md_start = 1; s.md_use = 1; s.rst = 1;
    drive(s);
    chk("reset_outs", {26'd0, obs}, 32'd0);

    // Load-use: exactly one bubble
    drive(wr(1, 2));
    drive(rd_rs(1, 1));
    chk("lu_stall", obs[5], 1);
    chk("lu_stall_rs", obs[4], 1);
    drive(rd_rs(1, 1));
    chk("lu_issue", obs[5], 0);

    // Load then branch on rt: two bubbles
    drive(wr(3, 2));
    hold(rd_rt(3, 0), n);
    chk("lb_bubbles", n, 2);

    // Zero register and unread operand
    drive(wr(0, 2));
    drive(rd_rs(0, 0));
    chk("zero_reg", obs[5], 0);
    drive(wr(5, 2));
    drive(rd_rs(5, 3));
    chk("unused_rs", obs[5], 0);

    // Both operands dependent
    drive(wr(6, 2));
    s = rd_rs(6, 0); s.rt = 6; s.tuse_rt = 0;
    drive(s);
    chk("dual_rs", obs[4], 1);
    chk("dual_rt", obs[3], 1);

    // tnew = 0 never stalls
    drive(wr(8, 0));
    drive(rd_rs(8, 0));
    chk("tnew0", obs[5], 0);

    // MD busy: mult then mflo, div then mflo
    s = nop(); s.valid = 1; s.md_use = 1;
    drive(md_op(0));
    chk("mult_go", obs[0], 1);
    hold(s, n);
    chk("mult_bubbles", n, 5);
    drive(md_op(1));
    chk("div_go", obs[0], 1);
    hold(s, n);
    chk("div_bubbles", n, 10);

    // Kill clears the register table, blocks issue, and leaves the running div alone
    drive(md_op(1));
    drive(wr(4, 2));
    s = rd_rs(4, 0); s.kill = 1;
    drive(s);
    drive(rd_rs(4, 0));
    chk("kill_clr", obs[4], 0);
    chk("kill_busy", obs[1], 1);
    s = wr(9, 3); s.kill = 1;
    drive(s);
    drive(rd_rs(9, 0));
    chk("kill_block", obs[5], 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(nop());
      if (obs[1]) n++;
      else break;
    end
    chk("kill_md_run", n, 5);

    // Newer writer overwrites older pending entry
    drive(wr(7, 2));
    drive(wr(7, 0));
    drive(rd_rs(7, 0));
    chk("overwrite", obs[5], 0);

    // Reset during div busy with a pending register
    drive(md_op(1));
    drive(wr(2, 3));
    s = nop(); s.valid = 1; s.md_use = 1; s.rst = 1;
    drive(s);
    chk("rst_cycle_busy", obs[1], 1);
    s = rd_rs(2, 0); s.md_use = 1;
    drive(s);
    chk("rst_busy", obs[1], 0);
    chk("rst_stall", obs[5], 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      s = nop();
      s.valid    = ($urandom_range(0, 9) < 8);
      s.rs       = 5'($urandom_range(0, 7));
      s.rt       = 5'($urandom_range(0, 7));
      s.tuse_rs  = 2'($urandom_range(0, 3));
      s.tuse_rt  = 2'($urandom_range(0, 3));
      s.wa       = 5'($urandom_range(0, 7));
      s.tnew     = 2'($urandom_range(0, 3));
      s.md_start = ($urandom_range(0, 9) == 0);
      s.md_div   = 1'($urandom_range(0, 1));
      s.md_use   = s.md_start || ($urandom_range(0, 19) == 0);
      s.kill     = ($urandom_range(0, 29) == 0);
      s.rst      = ($urandom_range(0, 99) == 0);
      drive(s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
